// File: rtl/lpc_pkg.sv
// Shared types, LPC nibble codes and nibble-select helpers for the LPC host I/O initiator.
// The ABORT state exists only when LPC_HOST_TIMEOUT_EN is defined.
package lpc_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_START   = 4'd1,
    ST_CYCTYPE = 4'd2,
    ST_ADDR    = 4'd3,
    ST_WDATA   = 4'd4,
    ST_TAR_H   = 4'd5,
    ST_SYNC    = 4'd6,
    ST_RDATA   = 4'd7,
    ST_TAR_P   = 4'd8,
    ST_DONE    = 4'd9
`ifdef LPC_HOST_TIMEOUT_EN
    ,
    ST_ABORT   = 4'd10
`endif
  } lpc_state_e;

  localparam logic [3:0] CYC_IO_RD       = 4'b0000;
  localparam logic [3:0] CYC_IO_WR       = 4'b0010;
  localparam logic [3:0] SYNC_READY      = 4'b0000;
  localparam logic [3:0] SYNC_SHORT_WAIT = 4'b0101;
  localparam logic [3:0] SYNC_LONG_WAIT  = 4'b0110;
  localparam logic [3:0] SYNC_ERROR      = 4'b1010;
  localparam logic [3:0] NIB_START       = 4'b0000;
  localparam logic [3:0] NIB_ABORT       = 4'b1111;
  localparam logic [3:0] NIB_TAR         = 4'b1111;

  // Address goes out most significant nibble first.
  function automatic logic [3:0] addr_nibble(input logic [15:0] addr, input logic [1:0] idx);
    logic [3:0] nib;
    case (idx)
      2'd0:    nib = addr[15:12];
      2'd1:    nib = addr[11:8];
      2'd2:    nib = addr[7:4];
      2'd3:    nib = addr[3:0];
      default: nib = 4'hF;
    endcase
    return nib;
  endfunction

  function automatic logic [3:0] data_nibble(input logic [7:0] data, input logic second,
                                             input logic lsn_first);
    return (second == lsn_first) ? data[7:4] : data[3:0];
  endfunction

endpackage

// File: rtl/lpc_sync_timer.sv
// Counts SYNC clocks and flags the last one allowed before an abort.
// Built only when LPC_HOST_TIMEOUT_EN is defined.
`ifdef LPC_HOST_TIMEOUT_EN
module lpc_sync_timer #(
  parameter int unsigned SYNC_TIMEOUT = 32'd32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic count_en,
  output logic expired
);

  localparam int unsigned CW = $clog2(SYNC_TIMEOUT) + 1;
  localparam logic [CW-1:0] LAST = CW'(SYNC_TIMEOUT - 32'd1);

  logic [CW-1:0] count_r;

  // Saturating count of SYNC clocks since the last load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= '0;
    end else if (count_en && (count_r != LAST)) begin
      count_r <= count_r + 1'b1;
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = count_en && (count_r == LAST);

endmodule
`endif

// File: rtl/lpc_host_io.sv
// LPC host I/O cycle initiator: one request at a time, full LAD/LFRAME# sequence, one-cycle response.
// Define LPC_HOST_TIMEOUT_EN to add the SYNC timeout counter and ABORT sequence.
module lpc_host_io
  import lpc_pkg::*;
#(
  parameter bit DATA_LSN_FIRST = 1'b1
`ifdef LPC_HOST_TIMEOUT_EN
  ,
  parameter int unsigned SYNC_TIMEOUT = 32'd32
`endif
) (
  input  logic        lpc_clock,
  input  logic        lpc_reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  input  logic [3:0]  lpc_ad_in,
  output logic [3:0]  lpc_ad_out,
  output logic        lpc_ad_oe,
  output logic        lpc_frame_n
);

  lpc_state_e  state_r;
  logic [2:0]  nib_r;
  logic        write_r;
  logic [15:0] addr_r;
  logic [7:0]  wdata_r;
  logic [7:0]  rdata_r;
  logic        err_r;
  logic        sync_expired;

`ifdef LPC_HOST_TIMEOUT_EN
  lpc_sync_timer #(.SYNC_TIMEOUT(SYNC_TIMEOUT)) u_sync_timer (
    .clk      (lpc_clock),
    .rst_n    (lpc_reset_n),
    .load     (state_r == ST_TAR_H),
    .count_en (state_r == ST_SYNC),
    .expired  (sync_expired)
  );
`else
  assign sync_expired = 1'b0;
`endif

  // Transaction FSM; bus outputs are set on the edge entering the phase that shows them.
  always_ff @(posedge lpc_clock or negedge lpc_reset_n) begin
    if (!lpc_reset_n) begin
      state_r     <= ST_IDLE;
      nib_r       <= 3'd0;
      write_r     <= 1'b0;
      addr_r      <= 16'h0000;
      wdata_r     <= 8'h00;
      rdata_r     <= 8'hFF;
      err_r       <= 1'b0;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= 8'hFF;
      rsp_err     <= 1'b0;
      lpc_ad_out  <= 4'hF;
      lpc_ad_oe   <= 1'b0;
      lpc_frame_n <= 1'b1;
    end else begin
      rsp_valid <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (req_ready && req_valid) begin
            req_ready   <= 1'b0;
            write_r     <= req_write;
            addr_r      <= req_addr;
            wdata_r     <= req_wdata;
            err_r       <= 1'b0;
            state_r     <= ST_START;
            lpc_frame_n <= 1'b0;
            lpc_ad_oe   <= 1'b1;
            lpc_ad_out  <= NIB_START;
          end else begin
            req_ready <= 1'b1;
          end
        end
        ST_START: begin
          state_r     <= ST_CYCTYPE;
          lpc_frame_n <= 1'b1;
          lpc_ad_out  <= write_r ? CYC_IO_WR : CYC_IO_RD;
        end
        ST_CYCTYPE: begin
          state_r    <= ST_ADDR;
          nib_r      <= 3'd0;
          lpc_ad_out <= addr_nibble(addr_r, 2'd0);
        end
        ST_ADDR: begin
          if (nib_r == 3'd3) begin
            nib_r <= 3'd0;
            if (write_r) begin
              state_r    <= ST_WDATA;
              lpc_ad_out <= data_nibble(wdata_r, 1'b0, DATA_LSN_FIRST);
            end else begin
              state_r    <= ST_TAR_H;
              lpc_ad_out <= NIB_TAR;
            end
          end else begin
            nib_r      <= nib_r + 3'd1;
            lpc_ad_out <= addr_nibble(addr_r, nib_r[1:0] + 2'd1);
          end
        end
        ST_WDATA: begin
          if (nib_r == 3'd0) begin
            nib_r      <= 3'd1;
            lpc_ad_out <= data_nibble(wdata_r, 1'b1, DATA_LSN_FIRST);
          end else begin
            nib_r      <= 3'd0;
            state_r    <= ST_TAR_H;
            lpc_ad_out <= NIB_TAR;
          end
        end
        ST_TAR_H: begin
          if (nib_r == 3'd0) begin
            nib_r     <= 3'd1;
            lpc_ad_oe <= 1'b0;
          end else begin
            nib_r   <= 3'd0;
            state_r <= ST_SYNC;
          end
        end
        // Wait codes and anything unrecognised keep us here until timeout (if built).
        ST_SYNC: begin
          case (lpc_ad_in)
            SYNC_READY, SYNC_ERROR: begin
              err_r   <= (lpc_ad_in == SYNC_ERROR);
              nib_r   <= 3'd0;
              state_r <= write_r ? ST_TAR_P : ST_RDATA;
            end
            default: begin
`ifdef LPC_HOST_TIMEOUT_EN
              if (sync_expired) begin
                nib_r       <= 3'd0;
                state_r     <= ST_ABORT;
                lpc_frame_n <= 1'b0;
                lpc_ad_oe   <= 1'b1;
                lpc_ad_out  <= NIB_ABORT;
              end
`endif
            end
          endcase
        end
        ST_RDATA: begin
          rdata_r <= DATA_LSN_FIRST ? {lpc_ad_in, rdata_r[7:4]} : {rdata_r[3:0], lpc_ad_in};
          if (nib_r == 3'd0) begin
            nib_r <= 3'd1;
          end else begin
            nib_r   <= 3'd0;
            state_r <= ST_TAR_P;
          end
        end
        ST_TAR_P: begin
          if (nib_r == 3'd0) begin
            nib_r <= 3'd1;
          end else begin
            nib_r     <= 3'd0;
            state_r   <= ST_DONE;
            rsp_valid <= 1'b1;
            rsp_err   <= err_r;
            rsp_rdata <= (write_r || err_r) ? 8'hFF : rdata_r;
          end
        end
        ST_DONE: begin
          state_r   <= ST_IDLE;
          req_ready <= 1'b1;
          rsp_err   <= 1'b0;
        end
`ifdef LPC_HOST_TIMEOUT_EN
        // Four framed abort clocks, then one clock with LFRAME# released.
        ST_ABORT: begin
          if (nib_r == 3'd3) begin
            nib_r       <= 3'd4;
            lpc_frame_n <= 1'b1;
            lpc_ad_oe   <= 1'b0;
          end else if (nib_r == 3'd4) begin
            nib_r     <= 3'd0;
            state_r   <= ST_DONE;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= 8'hFF;
          end else begin
            nib_r <= nib_r + 3'd1;
          end
        end
`endif
        default: begin
          state_r     <= ST_IDLE;
          nib_r       <= 3'd0;
          req_ready   <= 1'b0;
          lpc_frame_n <= 1'b1;
          lpc_ad_oe   <= 1'b0;
          lpc_ad_out  <= 4'hF;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lpc_host_io.sv
// Self-checking bench for lpc_host_io: per-clock bus trace and response against a phase-list model.
// Define LPC_HOST_TIMEOUT_EN to also exercise the SYNC timeout abort.
module tb_lpc_host_io;

  localparam int SYNC_T = 8;

  logic        lpc_clock = 1'b0;
  logic        lpc_reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [15:0] req_addr = 16'h0000;
  logic [7:0]  req_wdata = 8'h00;
  logic [3:0]  lpc_ad_in = 4'hF;
  logic        req_ready, rsp_valid, rsp_err, lpc_ad_oe, lpc_frame_n;
  logic [7:0]  rsp_rdata;
  logic [3:0]  lpc_ad_out;

  lpc_host_io #(
    .DATA_LSN_FIRST(1'b1)
`ifdef LPC_HOST_TIMEOUT_EN
    , .SYNC_TIMEOUT(SYNC_T)
`endif
  ) dut (
    .lpc_clock(lpc_clock), .lpc_reset_n(lpc_reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .lpc_ad_in(lpc_ad_in), .lpc_ad_out(lpc_ad_out), .lpc_ad_oe(lpc_ad_oe),
    .lpc_frame_n(lpc_frame_n)
  );

  always #5 lpc_clock = ~lpc_clock;

  int checks = 0;
  int errors = 0;

  // Per-clock word: {rsp_valid, req_ready, frame_n, oe, ad (F when not driven)}
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  logic [3:0] drv_q[$];
  logic [7:0] exp_rdata, obs_rdata;
  logic       exp_err, obs_err;

  function automatic logic [7:0] bus_word(input logic rv, input logic rdy, input logic fr,
                                          input logic oe, input logic [3:0] ad);
    return {rv, rdy, fr, oe, oe ? ad : 4'hF};
  endfunction

  function automatic void push_clk(input logic fr, input logic oe, input logic [3:0] ad,
                                   input logic [3:0] drv);
    exp_q.push_back(bus_word(1'b0, 1'b0, fr, oe, ad));
    drv_q.push_back(drv);
  endfunction

  // Expected LPC phase list for one transaction, and what the peripheral drives each clock.
  function automatic void model(input logic wr, input logic [15:0] addr, input logic [7:0] wdata,
                                input int nwait, input logic [3:0] wcode, input logic [3:0] scode,
                                input logic [7:0] pdata, input logic hang);
    exp_q.delete();
    drv_q.delete();
    push_clk(1'b0, 1'b1, 4'h0, 4'hF);
    push_clk(1'b1, 1'b1, wr ? 4'h2 : 4'h0, 4'hF);
    for (int i = 3; i >= 0; i--) push_clk(1'b1, 1'b1, addr[4*i +: 4], 4'hF);
    if (wr) begin
      push_clk(1'b1, 1'b1, wdata[3:0], 4'hF);
      push_clk(1'b1, 1'b1, wdata[7:4], 4'hF);
    end
    push_clk(1'b1, 1'b1, 4'hF, 4'hF);
    push_clk(1'b1, 1'b0, 4'hF, 4'hF);
    if (hang) begin
      for (int i = 0; i < SYNC_T; i++) push_clk(1'b1, 1'b0, 4'hF, 4'hF);
      for (int i = 0; i < 4; i++) push_clk(1'b0, 1'b1, 4'hF, 4'hF);
      push_clk(1'b1, 1'b0, 4'hF, 4'hF);
      exp_err = 1'b1;
      exp_rdata = 8'hFF;
    end else begin
      for (int i = 0; i < nwait; i++) push_clk(1'b1, 1'b0, 4'hF, wcode);
      push_clk(1'b1, 1'b0, 4'hF, scode);
      if (!wr) begin
        push_clk(1'b1, 1'b0, 4'hF, pdata[3:0]);
        push_clk(1'b1, 1'b0, 4'hF, pdata[7:4]);
      end
      push_clk(1'b1, 1'b0, 4'hF, 4'hF);
      push_clk(1'b1, 1'b0, 4'hF, 4'hF);
      exp_err = (scode == 4'hA);
      exp_rdata = (wr || exp_err) ? 8'hFF : pdata;
    end
    exp_q.push_back(bus_word(1'b1, 1'b0, 1'b1, 1'b0, 4'hF));
    drv_q.push_back(4'hF);
  endfunction

  // Present a request, wait (bounded) for acceptance, then record one word per clock.
  task automatic run_txn(input logic wr, input logic [15:0] addr, input logic [7:0] wdata,
                         output int waited);
    logic rdy;
    obs_q.delete();
    obs_rdata = 8'h00;
    obs_err = 1'bx;
    req_write = wr;
    req_addr = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    waited = 0;
    while (1'b1) begin
      rdy = req_ready;
      @(posedge lpc_clock);
      waited++;
      if (rdy || waited >= 20) break;
      @(negedge lpc_clock);
    end
    #1 req_valid = 1'b0;
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL accept: req_ready=0 after %0d clocks, required 1", waited);
      return;
    end
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge lpc_clock);
      obs_q.push_back(bus_word(rsp_valid, req_ready, lpc_frame_n, lpc_ad_oe, lpc_ad_out));
      if (rsp_valid) begin
        obs_rdata = rsp_rdata;
        obs_err = rsp_err;
      end
      lpc_ad_in = drv_q[k];
    end
    lpc_ad_in = 4'hF;
  endtask

  task automatic test_reset;
    logic [16:0] got;
    repeat (2) @(negedge lpc_clock);
    got = {lpc_frame_n, lpc_ad_oe, lpc_ad_out, req_ready, rsp_valid, rsp_err, rsp_rdata};
    checks++;
    if (got !== {1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 8'hFF}) begin
      errors++;
      $display("FAIL reset_values: got %h, required %h", got, {1'b1, 1'b0, 4'hF, 3'b000, 8'hFF});
    end
    lpc_reset_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_low: got %b, required 0", req_ready);
    end
    @(negedge lpc_clock);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_rise: got %b, required 1", req_ready);
    end
  endtask

  task automatic test_write_basic;
    int w;
    repeat (2) @(negedge lpc_clock);
    model(1'b1, 16'h0080, 8'hA5, 0, 4'hF, 4'h0, 8'h00, 1'b0);
    run_txn(1'b1, 16'h0080, 8'hA5, w);
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL write_basic clk%0d: got %h, required %h", k + 1, obs_q[k], exp_q[k]);
      end
    end
    checks++;
    if ({obs_err, obs_rdata} !== {exp_err, exp_rdata}) begin
      errors++;
      $display("FAIL write_basic rsp: got err=%b rdata=%h, required err=%b rdata=%h",
               obs_err, obs_rdata, exp_err, exp_rdata);
    end
  endtask

  task automatic test_read_basic;
    int w;
    repeat (2) @(negedge lpc_clock);
    model(1'b0, 16'h03F8, 8'h00, 0, 4'hF, 4'h0, 8'h3C, 1'b0);
    run_txn(1'b0, 16'h03F8, 8'h00, w);
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL read_basic clk%0d: got %h, required %h", k + 1, obs_q[k], exp_q[k]);
      end
    end
    checks++;
    if ({obs_err, obs_rdata} !== {1'b0, 8'h3C}) begin
      errors++;
      $display("FAIL read_basic rsp: got err=%b rdata=%h, required err=0 rdata=3c", obs_err, obs_rdata);
    end
  endtask

  task automatic test_sync_wait;
    int w;
    repeat (2) @(negedge lpc_clock);
    model(1'b0, 16'h03F8, 8'h00, 3, 4'h6, 4'h0, 8'h96, 1'b0);
    run_txn(1'b0, 16'h03F8, 8'h00, w);
    checks++;
    if (exp_q.size() != 17) begin
      errors++;
      $display("FAIL sync_wait length: model %0d clocks, required 17", exp_q.size());
    end
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL sync_wait clk%0d: got %h, required %h", k + 1, obs_q[k], exp_q[k]);
      end
    end
    checks++;
    if ({obs_err, obs_rdata} !== {exp_err, exp_rdata}) begin
      errors++;
      $display("FAIL sync_wait rsp: got err=%b rdata=%h, required err=%b rdata=%h",
               obs_err, obs_rdata, exp_err, exp_rdata);
    end
  endtask

  task automatic test_sync_error;
    int w;
    for (int t = 0; t < 2; t++) begin
      repeat (2) @(negedge lpc_clock);
      model(t == 0, 16'h1234, 8'h5A, 1, 4'h5, 4'hA, 8'h42, 1'b0);
      run_txn(t == 0, 16'h1234, 8'h5A, w);
      for (int k = 0; k < exp_q.size(); k++) begin
        checks++;
        if (obs_q[k] !== exp_q[k]) begin
          errors++;
          $display("FAIL sync_error[%0d] clk%0d: got %h, required %h", t, k + 1, obs_q[k], exp_q[k]);
        end
      end
      checks++;
      if ({obs_err, obs_rdata} !== {1'b1, 8'hFF}) begin
        errors++;
        $display("FAIL sync_error[%0d] rsp: got err=%b rdata=%h, required err=1 rdata=ff",
                 t, obs_err, obs_rdata);
      end
    end
  endtask

  task automatic test_random;
    logic [3:0] wcodes [4] = '{4'h5, 4'h6, 4'h3, 4'hF};
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  wdata, pdata;
    logic [3:0]  scode;
    int          nwait, w;
    for (int t = 0; t < 16; t++) begin
      wr = 1'($urandom_range(0, 1));
      addr = 16'($urandom);
      wdata = 8'($urandom);
      pdata = 8'($urandom);
      nwait = $urandom_range(0, 5);
      scode = ($urandom_range(0, 3) == 0) ? 4'hA : 4'h0;
      repeat ($urandom_range(1, 3)) @(negedge lpc_clock);
      model(wr, addr, wdata, nwait, wcodes[$urandom_range(0, 3)], scode, pdata, 1'b0);
      run_txn(wr, addr, wdata, w);
      for (int k = 0; k < exp_q.size(); k++) begin
        checks++;
        if (obs_q[k] !== exp_q[k]) begin
          errors++;
          $display("FAIL random[%0d] clk%0d: got %h, required %h", t, k + 1, obs_q[k], exp_q[k]);
        end
      end
      checks++;
      if ({obs_err, obs_rdata} !== {exp_err, exp_rdata}) begin
        errors++;
        $display("FAIL random[%0d] rsp: got err=%b rdata=%h, required err=%b rdata=%h",
                 t, obs_err, obs_rdata, exp_err, exp_rdata);
      end
    end
  endtask

  task automatic test_back_to_back;
    int w1, w2;
    repeat (2) @(negedge lpc_clock);
    model(1'b1, 16'h0070, 8'h11, 0, 4'hF, 4'h0, 8'h00, 1'b0);
    run_txn(1'b1, 16'h0070, 8'h11, w1);
    checks++;
    if (w1 != 1) begin
      errors++;
      $display("FAIL b2b idle_accept: got %0d clocks, required 1", w1);
    end
    // Second request is raised in the rsp_valid clock: one IDLE clock must separate them.
    model(1'b0, 16'h0071, 8'h00, 0, 4'hF, 4'h0, 8'hE7, 1'b0);
    run_txn(1'b0, 16'h0071, 8'h00, w2);
    checks++;
    if (w2 != 2) begin
      errors++;
      $display("FAIL b2b accept_after_rsp: got %0d clocks, required 2", w2);
    end
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL b2b clk%0d: got %h, required %h", k + 1, obs_q[k], exp_q[k]);
      end
    end
    checks++;
    if ({obs_err, obs_rdata} !== {1'b0, 8'hE7}) begin
      errors++;
      $display("FAIL b2b rsp: got err=%b rdata=%h, required err=0 rdata=e7", obs_err, obs_rdata);
    end
  endtask

  task automatic test_reset_mid;
    logic [16:0] got;
    logic        seen_rsp;
    int          w;
    repeat (2) @(negedge lpc_clock);
    req_write = 1'b1;
    req_addr = 16'hBEEF;
    req_wdata = 8'h33;
    req_valid = 1'b1;
    @(posedge lpc_clock);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge lpc_clock);
    checks++;
    if ({lpc_frame_n, lpc_ad_oe, lpc_ad_out} !== {1'b1, 1'b1, 4'hB}) begin
      errors++;
      $display("FAIL reset_mid in_addr: got %b%b%h, required 11b", lpc_frame_n, lpc_ad_oe, lpc_ad_out);
    end
    #2 lpc_reset_n = 1'b0;
    #1;
    got = {lpc_frame_n, lpc_ad_oe, lpc_ad_out, req_ready, rsp_valid, rsp_err, rsp_rdata};
    checks++;
    if (got !== {1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 8'hFF}) begin
      errors++;
      $display("FAIL reset_mid values: got %h, required %h", got, {1'b1, 1'b0, 4'hF, 3'b000, 8'hFF});
    end
    @(negedge lpc_clock);
    lpc_reset_n = 1'b1;
    seen_rsp = 1'b0;
    repeat (20) begin
      @(negedge lpc_clock);
      seen_rsp = seen_rsp | rsp_valid;
    end
    checks++;
    if (seen_rsp !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid no_rsp: got rsp_valid=%b, required 0", seen_rsp);
    end
    model(1'b0, 16'h02E8, 8'h00, 2, 4'h5, 4'h0, 8'h5D, 1'b0);
    run_txn(1'b0, 16'h02E8, 8'h00, w);
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL reset_mid next clk%0d: got %h, required %h", k + 1, obs_q[k], exp_q[k]);
      end
    end
    checks++;
    if ({obs_err, obs_rdata} !== {1'b0, 8'h5D}) begin
      errors++;
      $display("FAIL reset_mid next rsp: got err=%b rdata=%h, required err=0 rdata=5d", obs_err, obs_rdata);
    end
  endtask

`ifdef LPC_HOST_TIMEOUT_EN
  task automatic test_timeout;
    int w;
    repeat (2) @(negedge lpc_clock);
    model(1'b0, 16'h0060, 8'h00, 0, 4'hF, 4'hF, 8'h00, 1'b1);
    run_txn(1'b0, 16'h0060, 8'h00, w);
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL timeout clk%0d: got %h, required %h", k + 1, obs_q[k], exp_q[k]);
      end
    end
    checks++;
    if ({obs_err, obs_rdata} !== {1'b1, 8'hFF}) begin
      errors++;
      $display("FAIL timeout rsp: got err=%b rdata=%h, required err=1 rdata=ff", obs_err, obs_rdata);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_basic();
    test_read_basic();
    test_sync_wait();
    test_sync_error();
    test_random();
    test_back_to_back();
    test_reset_mid();
`ifdef LPC_HOST_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
